// File: rtl/pixel_serial_emitter_if.sv
// Frame-in / pixel-out handshake bundle for pixel_serial_emitter.
// pixel_last exists only when PIXEL_SERIAL_EMITTER_LAST_EN is defined.
interface pixel_serial_emitter_if #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned PIXEL_COUNT = 784
);
   logic                              frame_valid;
   logic                              frame_ready;
   logic [DATA_WIDTH*PIXEL_COUNT-1:0] frame_flat;
   logic                              pixel_bit;
   logic                              pixel_bit_valid;
   logic                              pixel_bit_ready;
   logic                              frame_done;
`ifdef PIXEL_SERIAL_EMITTER_LAST_EN
   logic                              pixel_last;

   // Emitter side
   modport master (
      input  frame_valid, frame_flat, pixel_bit_ready,
      output frame_ready, pixel_bit, pixel_bit_valid, frame_done, pixel_last
   );

   // Frame source / pixel sink side
   modport slave (
      output frame_valid, frame_flat, pixel_bit_ready,
      input  frame_ready, pixel_bit, pixel_bit_valid, frame_done, pixel_last
   );
`else
   // Emitter side
   modport master (
      input  frame_valid, frame_flat, pixel_bit_ready,
      output frame_ready, pixel_bit, pixel_bit_valid, frame_done
   );

   // Frame source / pixel sink side
   modport slave (
      output frame_valid, frame_flat, pixel_bit_ready,
      input  frame_ready, pixel_bit, pixel_bit_valid, frame_done
   );
`endif
endinterface

// File: rtl/pixel_serial_emitter.sv
// pixel_serial_emitter: latches one Q8.8 frame, binarises each sample against
// THRESHOLD with a single comparator and streams 1-bit pixels over valid/ready.
// Optional feature macro: PIXEL_SERIAL_EMITTER_LAST_EN adds the pixel_last output.
module pixel_serial_emitter #(
   parameter int unsigned                  PIXEL_COUNT = 784,
   parameter int unsigned                  DATA_WIDTH  = 16,
   parameter int unsigned                  PIXEL_SCALE = 8,
   parameter logic signed [DATA_WIDTH-1:0] THRESHOLD   = 16'sh0080
) (
   input logic                    clk,
   input logic                    rst,
   pixel_serial_emitter_if.master bus
);
   localparam int unsigned IDX_W    = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
   localparam logic [15:0] LAST_IDX = 16'(PIXEL_COUNT - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   // Fractional bits must leave room for a sign/integer part
   if (PIXEL_SCALE >= DATA_WIDTH) begin : g_bad_scale
      $error("PIXEL_SCALE must be smaller than DATA_WIDTH");
   end

   logic [0:0]            state;
   logic [0:0]            state_next;
   logic [15:0]           pix_idx;
   logic [15:0]           idx_next;
   logic [15:0]           idx_inc;
   logic [DATA_WIDTH-1:0] frame_buf [PIXEL_COUNT];
   logic [DATA_WIDTH-1:0] sample;
   logic                  cmp_bit;
   logic                  load;
   logic                  accept;
   logic                  bit_next;
   logic                  done_next;
   logic                  pixel_bit_q;
   logic                  pixel_valid_q;
   logic                  frame_ready_q;
   logic                  frame_done_q;

   assign bus.pixel_bit       = pixel_bit_q;
   assign bus.pixel_bit_valid = pixel_valid_q;
   assign bus.frame_ready     = frame_ready_q;
   assign bus.frame_done      = frame_done_q;

   // Next state, index and pixel; the one comparator sees pixel 0 of the
   // incoming frame in IDLE, otherwise the buffered pixel after pix_idx
   always_comb begin
      idx_inc    = (pix_idx == LAST_IDX) ? 16'd0 : pix_idx + 16'd1;
      sample     = (state == IDLE) ? bus.frame_flat[DATA_WIDTH-1:0]
                                   : frame_buf[IDX_W'(idx_inc)];
      cmp_bit    = ($signed(sample) >= THRESHOLD);
      accept     = pixel_valid_q && bus.pixel_bit_ready;
      state_next = state;
      idx_next   = pix_idx;
      bit_next   = pixel_bit_q;
      done_next  = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.frame_valid && frame_ready_q) begin
               load       = 1'b1;
               state_next = SEND;
               idx_next   = 16'd0;
               bit_next   = cmp_bit;
            end
         end
         SEND: begin
            if (accept) begin
               if (pix_idx == LAST_IDX) begin
                  state_next = IDLE;
                  idx_next   = 16'd0;
                  done_next  = 1'b1;
               end else begin
                  idx_next = idx_inc;
                  bit_next = cmp_bit;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered index and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_idx       <= 16'd0;
         pixel_bit_q   <= 1'b0;
         pixel_valid_q <= 1'b0;
         frame_ready_q <= 1'b1;
         frame_done_q  <= 1'b0;
      end else begin
         pix_idx       <= idx_next;
         pixel_bit_q   <= bit_next;
         pixel_valid_q <= (state_next == SEND);
         frame_ready_q <= (state_next == IDLE);
         frame_done_q  <= done_next;
      end
   end

   // Frame buffer: captured whole on frame accept, sole data source in SEND
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < int'(PIXEL_COUNT); i++) begin
            frame_buf[i] <= bus.frame_flat[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef PIXEL_SERIAL_EMITTER_LAST_EN
   logic pixel_last_q;

   assign bus.pixel_last = pixel_last_q;

   // Marks the final pixel of the frame, held with pixel_bit under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_last_q <= 1'b0;
      end else begin
         pixel_last_q <= (state_next == SEND) && (idx_next == LAST_IDX);
      end
   end
`endif

endmodule

// File: tb/tb_pixel_serial_emitter.sv
// Scoreboard bench for pixel_serial_emitter: expected bits are queued when a
// frame is accepted and popped on every pixel accept.
module tb_pixel_serial_emitter;
   localparam int DW     = 16;
   localparam int PC     = 784;
   localparam int BUDGET = 20000;

   logic clk;
   logic rst;

   pixel_serial_emitter_if #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC)) bus ();

   pixel_serial_emitter #(
      .PIXEL_COUNT(PC),
      .DATA_WIDTH (DW),
      .PIXEL_SCALE(8),
      .THRESHOLD  (16'sh0080)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int      n_tests = 0;
   int      n_fail  = 0;
   logic    q [$];
   logic [PC-1:0] pend_expb;
   int      acc_cnt     = 0;
   int      done_frames = 0;
   logic    in_frame    = 1'b0;
   logic    stalled     = 1'b0;
   logic    held_bit    = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // kind 0: all 0x0100; 1: checkerboard from 1; 2: checkerboard from 0; 3: threshold edges
   function automatic logic [DW*PC-1:0] mk_frame(input int kind);
      logic [DW*PC-1:0] f;
      logic [DW-1:0]    s;
      f = '0;
      for (int i = 0; i < PC; i++) begin
         case (kind)
            0: s = 16'h0100;
            1: s = (i % 2 == 0) ? 16'h0100 : 16'h0000;
            2: s = (i % 2 == 0) ? 16'h0000 : 16'h0100;
            default: begin
               case (i)
                  0: s = 16'h0080;
                  1: s = 16'h007F;
                  2: s = 16'hFF00;
                  3: s = 16'h7FFF;
                  default: s = 16'h0000;
               endcase
            end
         endcase
         f[i*DW +: DW] = s;
      end
      return f;
   endfunction

   function automatic logic [PC-1:0] mk_bits(input int kind);
      logic [PC-1:0] b;
      b = '0;
      for (int i = 0; i < PC; i++) begin
         case (kind)
            0: b[i] = 1'b1;
            1: b[i] = (i % 2 == 0);
            2: b[i] = (i % 2 == 1);
            default: b[i] = (i == 0) || (i == 3);
         endcase
      end
      return b;
   endfunction

   // One clock: check presented outputs, score accepts, advance past the edge
   task automatic cycle(input logic rdy);
      logic acc;
      logic facc;
      logic last;
      bus.pixel_bit_ready = rdy;
      acc  = bus.pixel_bit_valid && rdy;
      facc = bus.frame_valid && bus.frame_ready;
      last = 1'b0;
      check("pixel_bit_valid", 32'(bus.pixel_bit_valid), 32'(in_frame));
      check("frame_ready", 32'(bus.frame_ready), 32'(!in_frame));
`ifdef PIXEL_SERIAL_EMITTER_LAST_EN
      check("pixel_last", 32'(bus.pixel_last), 32'(in_frame && acc_cnt == PC-1));
`endif
      if (stalled) check("stall_hold", 32'(bus.pixel_bit), 32'(held_bit));
      if (acc) begin
         if (q.size() == 0) check("sb_underflow", 32'(q.size()), 32'd1);
         else check("pixel", 32'(bus.pixel_bit), 32'(q.pop_front()));
         acc_cnt++;
         if (acc_cnt == PC) begin
            last     = 1'b1;
            in_frame = 1'b0;
         end
      end
      if (facc) begin
         check("busy_accept", 32'(in_frame), 32'd0);
         for (int i = 0; i < PC; i++) q.push_back(pend_expb[i]);
         in_frame = 1'b1;
         acc_cnt  = 0;
      end
      stalled  = bus.pixel_bit_valid && !rdy;
      held_bit = bus.pixel_bit;
      @(posedge clk);
      #1;
      check("frame_done", 32'(bus.frame_done), 32'(last));
      if (last) done_frames++;
   endtask

   // Offer a frame and drain it; mode 0 ready, 1 random ~40%, 2 stall 5 on last pixel
   task automatic run_frame(input int kind, input int mode);
      int   d0;
      int   cyc;
      int   stall_n;
      logic rdy;
      bus.frame_flat  = mk_frame(kind);
      pend_expb       = mk_bits(kind);
      bus.frame_valid = 1'b1;
      d0      = done_frames;
      cyc     = 0;
      stall_n = 0;
      while (!in_frame && cyc < 50) begin
         cycle(1'b1);
         cyc++;
      end
      bus.frame_valid = 1'b0;
      check("frame_accept", 32'(in_frame), 32'd1);
      while (in_frame && cyc < BUDGET) begin
         case (mode)
            1: rdy = ($urandom_range(99) < 40);
            2: begin
               rdy = !(acc_cnt == PC-1 && stall_n < 5);
               if (!rdy) stall_n++;
            end
            default: rdy = 1'b1;
         endcase
         cycle(rdy);
         cyc++;
      end
      check("frame_timeout", 32'(in_frame), 32'd0);
      check("accept_count", 32'(acc_cnt), 32'(PC));
      check("done_count", 32'(done_frames - d0), 32'd1);
      check("sb_leftover", 32'(q.size()), 32'd0);
      cycle(1'b0);
   endtask

   initial begin
      int d0;
      int cyc;
      rst                 = 1'b1;
      bus.frame_valid     = 1'b0;
      bus.frame_flat      = '0;
      bus.pixel_bit_ready = 1'b0;
      pend_expb           = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_frame_ready", 32'(bus.frame_ready), 32'd1);
      check("rst_valid", 32'(bus.pixel_bit_valid), 32'd0);
      check("rst_pixel_bit", 32'(bus.pixel_bit), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done), 32'd0);
`ifdef PIXEL_SERIAL_EMITTER_LAST_EN
      check("rst_pixel_last", 32'(bus.pixel_last), 32'd0);
`endif
      rst = 1'b0;
      cycle(1'b0);

      run_frame(0, 0);
      run_frame(3, 0);
      run_frame(1, 0);
      run_frame(1, 1);
      run_frame(3, 2);

      // Frame B offered while A is in flight must wait for A to finish
      bus.frame_flat  = mk_frame(1);
      pend_expb       = mk_bits(1);
      bus.frame_valid = 1'b1;
      cyc = 0;
      while (!in_frame && cyc < 50) begin
         cycle(1'b1);
         cyc++;
      end
      bus.frame_valid = 1'b0;
      d0 = done_frames;
      while (done_frames == d0 && cyc < BUDGET) begin
         if (acc_cnt >= 200) begin
            bus.frame_flat  = mk_frame(2);
            pend_expb       = mk_bits(2);
            bus.frame_valid = 1'b1;
         end
         cycle(1'b1);
         cyc++;
      end
      check("busy_a_done", 32'(done_frames - d0), 32'd1);
      cycle(1'b1);
      check("busy_b_accept", 32'(in_frame), 32'd1);
      bus.frame_valid = 1'b0;
      d0 = done_frames;
      while (in_frame && cyc < 2*BUDGET) begin
         cycle(1'b1);
         cyc++;
      end
      check("busy_b_done", 32'(done_frames - d0), 32'd1);
      check("busy_b_count", 32'(acc_cnt), 32'(PC));
      cycle(1'b0);

      // Asynchronous reset in the middle of a frame
      bus.frame_flat  = mk_frame(1);
      pend_expb       = mk_bits(1);
      bus.frame_valid = 1'b1;
      cyc = 0;
      while (!in_frame && cyc < 50) begin
         cycle(1'b1);
         cyc++;
      end
      bus.frame_valid = 1'b0;
      while (in_frame && acc_cnt < 100 && cyc < BUDGET) begin
         cycle(1'b1);
         cyc++;
      end
      check("mid_acc_count", 32'(acc_cnt), 32'd100);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.pixel_bit_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.frame_ready), 32'd1);
      check("mid_rst_done", 32'(bus.frame_done), 32'd0);
`ifdef PIXEL_SERIAL_EMITTER_LAST_EN
      check("mid_rst_last", 32'(bus.pixel_last), 32'd0);
`endif
      q.delete();
      in_frame = 1'b0;
      stalled  = 1'b0;
      acc_cnt  = 0;
      @(posedge clk);
      #1;
      check("mid_rst_done_hold", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;
      cycle(1'b0);
      run_frame(3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pixel_serial_emitter.md
# pixel_serial_emitter

Transmit-side counterpart of `pixel_serial_loader`. Accepts one flattened Q8.8 frame of `PIXEL_COUNT` samples, typically generator output. Binarises each sample against a fixed threshold and streams the result out as 1-bit pixels over a valid/ready handshake. Pixel order and the bit format on the wire match the loader's input, so emitter → loader forms an identity loopback for binary frames.

## Interface
Parameters:
- `PIXEL_COUNT`, 784: pixels per frame (28x28).
- `DATA_WIDTH`, 16: bits per sample, two's complement.
- `PIXEL_SCALE`, 8: fractional bits (Q format). Informational only; `THRESHOLD` is expressed in the same format.
- `THRESHOLD`, 16'sh0080: signed binarisation threshold (0.5 in Q8.8).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `frame_valid`  in  1: `frame_flat` holds a frame to send.
- `frame_ready`  out  1: emitter can accept a frame.
- `frame_flat`  in  `DATA_WIDTH*PIXEL_COUNT`: pixel i is at `[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]`.
- `pixel_bit`  out  1: current binary pixel.
- `pixel_bit_valid`  out  1: `pixel_bit` is valid.
- `pixel_bit_ready`  in  1: sink accepts `pixel_bit`.
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted.
- `pixel_last`  out  1: present only with `PIXEL_SERIAL_EMITTER_LAST_EN` (see Configuration).

## Operation
- State machine states: IDLE, SEND.
- IDLE:
  - `frame_ready`=1, `pixel_bit_valid`=0.
  - On `frame_valid && frame_ready`: register the whole `frame_flat` into an internal buffer, set `pix_idx`=0, register `pixel_bit` for pixel 0, go to SEND.
- SEND:
  - `frame_ready`=0, `pixel_bit_valid`=1.
  - Pixel accept = `pixel_bit_valid && pixel_bit_ready`.
  - On accept with `pix_idx` < `PIXEL_COUNT-1`: increment `pix_idx`, register `pixel_bit` for the next pixel.
  - On accept with `pix_idx` == `PIXEL_COUNT-1`: go to IDLE, pulse `frame_done`, set `pix_idx`=0.
- Binarisation: `pixel_bit` = ($signed(sample) >= $signed(`THRESHOLD`)).
  - Exactly one comparator, fed from the latched buffer through an index mux.
  - Negative samples always give 0.
- `frame_valid` and changes to `frame_flat` during SEND are ignored. The latched copy is the sole data source.
- `pix_idx` is 16 bits wide and never exceeds `PIXEL_COUNT-1`. There is no wrap-around within a frame.

## Timing
- Reset values:
  - `frame_ready`=1 (state IDLE).
  - `pixel_bit`=0, `pixel_bit_valid`=0, `frame_done`=0, `pixel_last`=0.
  - Buffer contents are don't-care.
- Frame accepted at edge N: `pixel_bit_valid`=1 with pixel 0 from edge N onward.
- With `pixel_bit_ready` held high, one pixel is accepted per cycle. A frame occupies exactly `PIXEL_COUNT` consecutive accept cycles.
- Backpressure: while `pixel_bit_valid`=1 and `pixel_bit_ready`=0, `pixel_bit` is held stable. `pixel_bit_valid` never deasserts before an accept.
- Last accept at edge M:
  - `frame_done`=1 and `frame_ready`=1 during the cycle after M.
  - `pixel_bit_valid`=0 from M.
  - Earliest next frame accept is edge M+1.
- Reset mid-frame: the frame is abandoned with no `frame_done`, and the block returns to IDLE immediately (asynchronous).

## Configuration
- Macro: `PIXEL_SERIAL_EMITTER_LAST_EN`.
- Defined:
  - Output `pixel_last` exists.
  - `pixel_last` = `pixel_bit_valid && (pix_idx == PIXEL_COUNT-1)`, held with `pixel_bit` under backpressure.
  - Reset value 0.
- Undefined: the `pixel_last` port and its logic are absent; all other behaviour is identical.

## Test plan
- Loopback, all samples 16'h0100, sink always ready:
  - Exactly 784 accepts, all `pixel_bit`=1.
  - `frame_done` pulses once, one cycle after the 784th accept.
  - Loader `frame_flat` equals the input frame.
- Threshold edges: pixels 0..3 = 16'h0080, 16'h007F, 16'hFF00, 16'h7FFF → bits 1, 0, 0, 1. Checkerboard frame (0x0100/0x0000) → alternating 1/0 starting with 1.
- Backpressure:
  - Random `pixel_bit_ready` (~40% duty) on a checkerboard frame.
  - `pixel_bit` stays stable while stalled, the sequence is unchanged, and the accept count is 784.
  - `frame_ready` stays 0 until the frame ends.
- Busy rejection:
  - Frame A is in flight; assert `frame_valid` with frame B at pixel 200 and hold it.
  - Output stays A for all 784 bits.
  - B is accepted at the first edge `frame_ready`=1, and its pixel 0 appears the next cycle.
- Reset mid-frame:
  - Assert `rst` after 100 accepts.
  - `pixel_bit_valid`=0 and `frame_ready`=1 immediately, with no `frame_done`.
  - A new frame then emits from pixel 0.
- With `PIXEL_SERIAL_EMITTER_LAST_EN` defined:
  - `pixel_last`=1 only while pixel 783 is presented, including across a 5-cycle stall on that pixel.
  - `pixel_last` is 0 otherwise and after reset.
